// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: opcode field geometry, halt opcode, fetch FSM states.
package pipeline_pkg;

  localparam int unsigned OPWIDTH = 4;
  localparam logic [OPWIDTH-1:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    RUN,
    HALT_PEND,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction memory port, hazard/redirect controls, IF/ID outputs.
interface fetch_stage_if #(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned INSTRUCTIONWIDTH = 24
);

  logic [WIDTH-1:0]            imem_addr;
  logic [INSTRUCTIONWIDTH-1:0] imem_rdata;
  logic                        stall;
  logic                        branch_taken;
  logic [WIDTH-1:0]            branch_target;
  logic [INSTRUCTIONWIDTH-1:0] if_instr;
  logic [WIDTH-1:0]            if_pc;
  logic                        if_valid;
  logic                        halted;
  logic [WIDTH-1:0]            fetch_count;

  // Fetch stage side.
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  branch_taken,
    input  branch_target,
    output if_instr,
    output if_pc,
    output if_valid,
    output halted,
    output fetch_count
  );

  // Memory / hazard unit / decode side.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output branch_taken,
    output branch_target,
    input  if_instr,
    input  if_pc,
    input  if_valid,
    input  halted,
    input  fetch_count
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter register: reset value, load-target over increment over hold.
module pc_reg #(
  parameter int unsigned    WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc
);

  // PC update; increment wraps naturally at the top of the address space.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_VAL;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, IF/ID register, redirect/stall handling and halt drain.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned      WIDTH            = 16,
  parameter int unsigned      INSTRUCTIONWIDTH = 24,
  parameter logic [WIDTH-1:0] RESET_PC         = '0,
  parameter int unsigned      HALT_DRAIN       = 3
) (
  input logic         clk,
  input logic         reset,
  fetch_stage_if.master bus
);

  localparam int unsigned DRAINW = (HALT_DRAIN < 1) ? 1 : $clog2(HALT_DRAIN + 1);

  fetch_state_t                state_q, state_d;
  logic [DRAINW-1:0]           drain_q, drain_d;
  logic [WIDTH-1:0]            pc;
  logic                        pc_load, pc_inc;
  logic                        ifid_load, ifid_clr, cnt_inc;
  logic [INSTRUCTIONWIDTH-1:0] if_instr_q;
  logic [WIDTH-1:0]            if_pc_q;
  logic                        if_valid_q;
  logic                        halted_q;
  logic [WIDTH-1:0]            fetch_count_q;
  logic [OPWIDTH-1:0]          opcode_c;

  assign opcode_c = bus.imem_rdata[INSTRUCTIONWIDTH-1 -: OPWIDTH];

  pc_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (bus.branch_target),
    .pc     (pc)
  );

  // Next-state and control decode: redirect beats stall beats normal fetch.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    ifid_load = 1'b0;
    ifid_clr  = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.branch_taken) begin
          pc_load  = 1'b1;
          ifid_clr = 1'b1;
        end else if (!bus.stall) begin
          ifid_load = 1'b1;
          cnt_inc   = 1'b1;
          if (opcode_c == OP_HALT) begin
            state_d = HALT_PEND;
            drain_d = '0;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      HALT_PEND: begin
        if (bus.branch_taken) begin
          state_d  = RUN;
          pc_load  = 1'b1;
          ifid_clr = 1'b1;
          drain_d  = '0;
        end else if (!bus.stall) begin
          ifid_clr = 1'b1;
          if (drain_q == DRAINW'(HALT_DRAIN)) begin
            state_d = HALTED;
          end else begin
            drain_d = drain_q + DRAINW'(1);
          end
        end
      end
      HALTED: begin
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, drain counter and sticky halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == HALTED);
    end
  end

  // IF/ID pipeline register and fetched-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      if (ifid_load) begin
        if_instr_q <= bus.imem_rdata;
        if_pc_q    <= pc;
        if_valid_q <= 1'b1;
      end else if (ifid_clr) begin
        if_valid_q <= 1'b0;
      end
      if (cnt_inc) begin
        fetch_count_q <= fetch_count_q + WIDTH'(1);
      end
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: two instances (reset PC 0 and FFFF) against a reference model.
module tb_fetch_stage;

  localparam int unsigned W  = 16;
  localparam int unsigned IW = 24;
  localparam int unsigned HD = 3;

  typedef struct {
    logic [W-1:0]  pc;
    logic [IW-1:0] instr;
    logic [W-1:0]  ipc;
    bit            valid;
    bit            halted;
    logic [W-1:0]  cnt;
    int            mode;   // 0 fetching, 1 halt seen, 2 halted
    int            drain;  // non-stalled edges since the halt word was loaded
  } mdl_t;

  logic          clk;
  bit            reset;
  bit            stall;
  bit            br;
  logic [W-1:0]  tgt;
  logic [IW-1:0] mem [0:65535];
  mdl_t          ma, mb;
  int            n_assert;
  int            n_fail;

  fetch_stage_if #(.WIDTH(W), .INSTRUCTIONWIDTH(IW)) ifa ();
  fetch_stage_if #(.WIDTH(W), .INSTRUCTIONWIDTH(IW)) ifb ();

  assign ifa.imem_rdata    = mem[ifa.imem_addr];
  assign ifa.stall         = stall;
  assign ifa.branch_taken  = br;
  assign ifa.branch_target = tgt;
  assign ifb.imem_rdata    = mem[ifb.imem_addr];
  assign ifb.stall         = stall;
  assign ifb.branch_taken  = br;
  assign ifb.branch_target = tgt;

  fetch_stage #(.WIDTH(W), .INSTRUCTIONWIDTH(IW), .RESET_PC(16'h0000), .HALT_DRAIN(HD)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.master)
  );

  fetch_stage #(.WIDTH(W), .INSTRUCTIONWIDTH(IW), .RESET_PC(16'hFFFF), .HALT_DRAIN(HD)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One edge of the architectural behaviour.
  function automatic mdl_t step(mdl_t m, bit rst, bit st, bit b, logic [W-1:0] t,
                                logic [IW-1:0] rd, logic [W-1:0] rpc);
    mdl_t n = m;
    if (rst) begin
      n.pc = rpc; n.instr = '0; n.ipc = '0; n.valid = 0; n.halted = 0;
      n.cnt = '0; n.mode = 0; n.drain = 0;
      return n;
    end
    if (m.mode == 0) begin
      if (b) begin
        n.pc = t; n.valid = 0;
      end else if (!st) begin
        n.instr = rd; n.ipc = m.pc; n.valid = 1; n.cnt = m.cnt + 16'd1;
        if (rd[23:20] == 4'hF) begin
          n.mode = 1; n.drain = 0;
        end else begin
          n.pc = m.pc + 16'd1;
        end
      end
    end else if (m.mode == 1) begin
      if (b) begin
        n.mode = 0; n.pc = t; n.valid = 0; n.drain = 0;
      end else if (!st) begin
        n.valid = 0;
        n.drain = m.drain + 1;
        if (n.drain == HD + 1) begin
          n.mode = 2; n.halted = 1;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("a.imem_addr",   64'(ifa.imem_addr),   64'(ma.pc));
    chk("a.if_instr",    64'(ifa.if_instr),    64'(ma.instr));
    chk("a.if_pc",       64'(ifa.if_pc),       64'(ma.ipc));
    chk("a.if_valid",    64'(ifa.if_valid),    64'(ma.valid));
    chk("a.halted",      64'(ifa.halted),      64'(ma.halted));
    chk("a.fetch_count", 64'(ifa.fetch_count), 64'(ma.cnt));
    chk("b.imem_addr",   64'(ifb.imem_addr),   64'(mb.pc));
    chk("b.if_instr",    64'(ifb.if_instr),    64'(mb.instr));
    chk("b.if_pc",       64'(ifb.if_pc),       64'(mb.ipc));
    chk("b.if_valid",    64'(ifb.if_valid),    64'(mb.valid));
    chk("b.halted",      64'(ifb.halted),      64'(mb.halted));
    chk("b.fetch_count", 64'(ifb.fetch_count), 64'(mb.cnt));
  endtask

  // Advance one clock: model steps with the pre-edge inputs, outputs compared at the falling edge.
  task automatic tick();
    mdl_t na, nb;
    na = step(ma, reset, stall, br, tgt, mem[ma.pc], 16'h0000);
    nb = step(mb, reset, stall, br, tgt, mem[mb.pc], 16'hFFFF);
    @(posedge clk);
    ma = na;
    mb = nb;
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill_safe();
    for (int i = 0; i < 65536; i++) begin
      mem[i] = {4'($urandom_range(0, 14)), 20'($urandom)};
    end
  endtask

  task automatic do_reset();
    reset = 1; stall = 0; br = 0;
    tick();
    reset = 0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1; stall = 0; br = 0; tgt = '0;
    fill_safe();

    // Reset values.
    do_reset();
    chk("rst.a.addr",  64'(ifa.imem_addr), 64'h0);
    chk("rst.a.valid", 64'(ifa.if_valid), 64'h0);
    chk("rst.a.count", 64'(ifa.fetch_count), 64'h0);
    chk("rst.b.addr",  64'(ifb.imem_addr), 64'hFFFF);

    // Free-running fetch of words 0..3.
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("seq.if_pc",    64'(ifa.if_pc), 64'(k));
      chk("seq.if_instr", 64'(ifa.if_instr), 64'(mem[k]));
      chk("seq.if_valid", 64'(ifa.if_valid), 64'h1);
    end
    chk("seq.count", 64'(ifa.fetch_count), 64'd4);

    // Stall two cycles with pc at 5.
    tick();
    stall = 1;
    ticks(2);
    chk("stall.addr",  64'(ifa.imem_addr), 64'd5);
    chk("stall.if_pc", 64'(ifa.if_pc), 64'd4);
    chk("stall.count", 64'(ifa.fetch_count), 64'd5);
    stall = 0;
    tick();
    chk("resume.if_pc", 64'(ifa.if_pc), 64'd5);

    // Redirect wins over stall.
    stall = 1; br = 1; tgt = 16'h0040;
    tick();
    chk("redir.valid", 64'(ifa.if_valid), 64'h0);
    chk("redir.addr",  64'(ifa.imem_addr), 64'h40);
    stall = 0; br = 0;
    tick();
    chk("redir.if_pc", 64'(ifa.if_pc), 64'h40);
    chk("redir.vld2",  64'(ifa.if_valid), 64'h1);

    // Halt word at address 8 drains then halts; redirects are then ignored.
    mem[8] = {4'hF, 20'h00ABC};
    do_reset();
    ticks(9);
    chk("halt.if_pc",  64'(ifa.if_pc), 64'd8);
    chk("halt.valid",  64'(ifa.if_valid), 64'h1);
    chk("halt.addr",   64'(ifa.imem_addr), 64'd8);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt.early", 64'(ifa.halted), 64'h0);
    end
    tick();
    chk("halt.rise", 64'(ifa.halted), 64'h1);
    br = 1; tgt = 16'h0033;
    tick();
    chk("halt.ign.h",    64'(ifa.halted), 64'h1);
    chk("halt.ign.addr", 64'(ifa.imem_addr), 64'd8);
    br = 0;
    ticks(3);

    // Halt on a squashed path: redirect during the drain.
    do_reset();
    ticks(10);
    br = 1; tgt = 16'h0010;
    tick();
    chk("sq.addr",  64'(ifa.imem_addr), 64'h10);
    chk("sq.valid", 64'(ifa.if_valid), 64'h0);
    br = 0;
    tick();
    chk("sq.if_pc", 64'(ifa.if_pc), 64'h10);
    ticks(6);
    chk("sq.halted", 64'(ifa.halted), 64'h0);

    // Reset PC at the top of memory wraps; reset mid-stall.
    do_reset();
    tick();
    chk("wrap.pc0", 64'(ifb.if_pc), 64'hFFFF);
    tick();
    chk("wrap.pc1", 64'(ifb.if_pc), 64'h0000);
    stall = 1;
    tick();
    reset = 1;
    tick();
    reset = 0; stall = 0;
    chk("rs.b.addr",  64'(ifb.imem_addr), 64'hFFFF);
    chk("rs.b.valid", 64'(ifb.if_valid), 64'h0);
    chk("rs.b.instr", 64'(ifb.if_instr), 64'h0);
    chk("rs.b.count", 64'(ifb.fetch_count), 64'h0);

    // Random traffic with scattered halt words.
    fill_safe();
    for (int i = 0; i < 400; i++) begin
      mem[$urandom_range(0, 65535)][23:20] = 4'hF;
    end
    for (int i = 0; i < 300; i++) begin
      mem[$urandom_range(0, 63)][23:20] = 4'hF;
      mem[$urandom_range(0, 63)][23:20] = 4'($urandom_range(0, 14));
    end
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 25);
      br    = ($urandom_range(0, 99) < 12);
      tgt   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      tick();
    end
    reset = 0; stall = 0; br = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
